// File: rtl/enigma_pkg.sv
// Shared Enigma constants: letter type, rotor/reflector wiring, notches and
// the mod-26 helpers used by the rotor stages and the stepping logic.
package enigma_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int NUM_ROTORS  = 5;

  typedef logic [4:0] letter_t;
  typedef logic [2:0] rotor_sel_t;
  typedef letter_t [NUM_LETTERS-1:0] wiring_t;
  typedef wiring_t [NUM_ROTORS-1:0] rotor_bank_t;

  typedef struct packed {
    rotor_sel_t sel_l;
    rotor_sel_t sel_m;
    rotor_sel_t sel_r;
    letter_t    pos_l;
    letter_t    pos_m;
    letter_t    pos_r;
  } settings_t;

  localparam settings_t DEFAULT_SETTINGS = '{
    sel_l: 3'd0, sel_m: 3'd1, sel_r: 3'd2,
    pos_l: 5'd0, pos_m: 5'd0, pos_r: 5'd0
  };

  // Wiring strings are written the traditional way, leftmost char maps A.
  function automatic wiring_t str_to_wiring(input logic [8*NUM_LETTERS-1:0] s);
    wiring_t    w;
    logic [7:0] ch;
    logic [7:0] idx;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      ch   = s[8*(NUM_LETTERS-1-i) +: 8];
      idx  = ch - 8'd65;
      w[i] = idx[4:0];
    end
    return w;
  endfunction

  function automatic wiring_t invert_wiring(input wiring_t w);
    wiring_t r;
    r = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      r[w[i]] = letter_t'(i);
    end
    return r;
  endfunction

  localparam rotor_bank_t ROTOR_FWD = {
    str_to_wiring("VZBRGITYUPSDNHLXAWMJQOFECK"),
    str_to_wiring("ESOVPZJAYQUIRHXLNFTGKDCMWB"),
    str_to_wiring("BDFHJLCPRTXVZNYEIWGAKMUSQO"),
    str_to_wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE"),
    str_to_wiring("EKMFLGDQVZNTOWYHXUSPAIBRCJ")
  };

  localparam rotor_bank_t ROTOR_INV = {
    invert_wiring(ROTOR_FWD[4]),
    invert_wiring(ROTOR_FWD[3]),
    invert_wiring(ROTOR_FWD[2]),
    invert_wiring(ROTOR_FWD[1]),
    invert_wiring(ROTOR_FWD[0])
  };

  localparam wiring_t REFLECTOR_B = str_to_wiring("YRUHQSLDPXNGOKMIEBFZCWVJAT");

  // Index 0 is rotor I (notch Q) through index 4, rotor V (notch Z).
  localparam letter_t [NUM_ROTORS-1:0] NOTCH = {5'd25, 5'd9, 5'd21, 5'd4, 5'd16};

  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'(NUM_LETTERS)) s = s - 6'(NUM_LETTERS);
    return s[4:0];
  endfunction

  function automatic letter_t sub26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + 6'(NUM_LETTERS) - {1'b0, b};
    if (s >= 6'(NUM_LETTERS)) s = s - 6'(NUM_LETTERS);
    return s[4:0];
  endfunction

endpackage

// File: rtl/rotor_stage.sv
// One pass through a single rotor, forward or inverse, at a given position.
module rotor_stage
  import enigma_pkg::*;
(
  input  rotor_sel_t rotor,
  input  letter_t    pos,
  input  logic       inverse,
  input  letter_t    letter,
  output letter_t    mapped
);

  rotor_sel_t rsel;
  letter_t    idx;
  letter_t    wired;

  // Out-of-range selects cannot be loaded; clamp so the lookup stays defined.
  always_comb begin
    rsel   = (rotor > 3'd4) ? 3'd0 : rotor;
    idx    = add26(letter, pos);
    wired  = inverse ? ROTOR_INV[rsel][idx] : ROTOR_FWD[rsel][idx];
    mapped = sub26(wired, pos);
  end

endmodule

// File: rtl/enigma_encoder.sv
// Streaming three-rotor Enigma encoder: steps rotors on each accepted letter
// and enciphers it through a three-stage pipeline (fixed 2-cycle latency).
module enigma_encoder
  import enigma_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  output logic        cfg_error_out,
  input  logic        data_valid_in,
  input  logic [4:0]  data_in,
  output logic        data_ready_out,
  output logic        data_valid_out,
  output logic [4:0]  data_out,
  output logic [14:0] pos_out
);

  settings_t cfg;
  settings_t stepped;
  settings_t load_cfg;
  logic      load_bad;
  logic      letter_ok;

  settings_t s1_set;
  letter_t   s1_letter;
  logic      s1_valid;
  settings_t s2_set;
  letter_t   s2_letter;
  logic      s2_valid;

  letter_t   fwd_r, fwd_m, fwd_l, reflected;
  letter_t   inv_l, inv_m, inv_r;

  assign data_ready_out = ~load_in;
  assign letter_ok      = data_valid_in & ~load_in & (data_in < 5'(NUM_LETTERS));
  assign pos_out        = {cfg.pos_l, cfg.pos_m, cfg.pos_r};

  always_comb begin
    load_cfg.sel_l = rotor_select_in[8:6];
    load_cfg.sel_m = rotor_select_in[5:3];
    load_cfg.sel_r = rotor_select_in[2:0];
    load_cfg.pos_l = rotor_initial_in[14:10];
    load_cfg.pos_m = rotor_initial_in[9:5];
    load_cfg.pos_r = rotor_initial_in[4:0];
    load_bad = (load_cfg.sel_l > 3'd4) || (load_cfg.sel_m > 3'd4) || (load_cfg.sel_r > 3'd4) ||
               (load_cfg.sel_l == load_cfg.sel_m) || (load_cfg.sel_l == load_cfg.sel_r) ||
               (load_cfg.sel_m == load_cfg.sel_r) ||
               (load_cfg.pos_l > 5'd25) || (load_cfg.pos_m > 5'd25) || (load_cfg.pos_r > 5'd25);
  end

  // Notch tests use the pre-step positions; the middle rotor's own notch gives the double step.
  always_comb begin
    stepped       = cfg;
    stepped.pos_r = add26(cfg.pos_r, 5'd1);
    if ((cfg.pos_r == NOTCH[cfg.sel_r]) || (cfg.pos_m == NOTCH[cfg.sel_m]))
      stepped.pos_m = add26(cfg.pos_m, 5'd1);
    if (cfg.pos_m == NOTCH[cfg.sel_m])
      stepped.pos_l = add26(cfg.pos_l, 5'd1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cfg           <= DEFAULT_SETTINGS;
      cfg_error_out <= 1'b0;
    end else if (load_in) begin
      cfg_error_out <= load_bad;
      if (!load_bad) cfg <= load_cfg;
    end else if (letter_ok) begin
      cfg <= stepped;
    end
  end

  rotor_stage u_fwd_r (.rotor(s1_set.sel_r), .pos(s1_set.pos_r), .inverse(1'b0), .letter(s1_letter), .mapped(fwd_r));
  rotor_stage u_fwd_m (.rotor(s1_set.sel_m), .pos(s1_set.pos_m), .inverse(1'b0), .letter(fwd_r),     .mapped(fwd_m));
  rotor_stage u_fwd_l (.rotor(s1_set.sel_l), .pos(s1_set.pos_l), .inverse(1'b0), .letter(fwd_m),     .mapped(fwd_l));

  assign reflected = REFLECTOR_B[fwd_l];

  rotor_stage u_inv_l (.rotor(s2_set.sel_l), .pos(s2_set.pos_l), .inverse(1'b1), .letter(s2_letter), .mapped(inv_l));
  rotor_stage u_inv_m (.rotor(s2_set.sel_m), .pos(s2_set.pos_m), .inverse(1'b1), .letter(inv_l),     .mapped(inv_m));
  rotor_stage u_inv_r (.rotor(s2_set.sel_r), .pos(s2_set.pos_r), .inverse(1'b1), .letter(inv_m),     .mapped(inv_r));

  // Each stage carries its own copy of the settings so a load never disturbs letters in flight.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_valid       <= 1'b0;
      s1_set         <= DEFAULT_SETTINGS;
      s1_letter      <= '0;
      s2_valid       <= 1'b0;
      s2_set         <= DEFAULT_SETTINGS;
      s2_letter      <= '0;
      data_valid_out <= 1'b0;
      data_out       <= '0;
    end else begin
      s1_valid       <= letter_ok;
      s2_valid       <= s1_valid;
      data_valid_out <= s2_valid;
      if (letter_ok) begin
        s1_set    <= stepped;
        s1_letter <= data_in;
      end
      if (s1_valid) begin
        s2_set    <= s1_set;
        s2_letter <= reflected;
      end
      if (s2_valid) data_out <= inv_r;
    end
  end

endmodule

// File: tb/tb_enigma_encoder.sv
// Directed testbench for enigma_encoder: known Enigma vectors, stepping,
// config rejection, invalid letters, mid-stream load and reset.
module tb_enigma_encoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        load_in = 1'b0;
  logic [8:0]  rotor_select_in = '0;
  logic [14:0] rotor_initial_in = '0;
  logic        cfg_error_out;
  logic        data_valid_in = 1'b0;
  logic [4:0]  data_in = '0;
  logic        data_ready_out;
  logic        data_valid_out;
  logic [4:0]  data_out;
  logic [14:0] pos_out;

  int testCount = 0;
  int failCount = 0;
  int cycleCount = 0;

  logic [4:0] outQ[$];
  int         outCyc[$];
  int         accCyc[$];

  localparam logic [8:0]  SEL_I_II_III = {3'd0, 3'd1, 3'd2};
  localparam logic [14:0] POS_AAA      = 15'd0;

  logic [4:0] canon[5];
  logic [4:0] cipher[26];

  enigma_encoder dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .load_in(load_in),
    .rotor_select_in(rotor_select_in),
    .rotor_initial_in(rotor_initial_in),
    .cfg_error_out(cfg_error_out),
    .data_valid_in(data_valid_in),
    .data_in(data_in),
    .data_ready_out(data_ready_out),
    .data_valid_out(data_valid_out),
    .data_out(data_out),
    .pos_out(pos_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycleCount <= cycleCount + 1;

  // Collect every ciphertext letter with the cycle it appeared in.
  always @(negedge clk_in) begin
    if (data_valid_out === 1'b1) begin
      outQ.push_back(data_out);
      outCyc.push_back(cycleCount);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after a rising edge and are consumed at the following edge.
  task automatic applyStimulus(input logic v, input logic [4:0] d, input logic ld,
                               input logic [8:0] sel, input logic [14:0] ini);
    @(posedge clk_in);
    #1;
    data_valid_in    = v;
    data_in          = d;
    load_in          = ld;
    rotor_select_in  = sel;
    rotor_initial_in = ini;
    if (v && !ld && d < 5'd26) accCyc.push_back(cycleCount + 1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 9'd0, 15'd0);
  endtask

  task automatic sendLetter(input logic [4:0] d);
    applyStimulus(1'b1, d, 1'b0, 9'd0, 15'd0);
  endtask

  task automatic loadCfg(input logic [8:0] sel, input logic [14:0] ini);
    applyStimulus(1'b0, 5'd0, 1'b1, sel, ini);
  endtask

  task automatic clearQ();
    outQ.delete();
    outCyc.delete();
    accCyc.delete();
  endtask

  // Bounded wait for n outputs, then a few quiet cycles to catch extras.
  task automatic drain(input int n, input string tag);
    int waited;
    waited = 0;
    while (outQ.size() < n && waited < 20) begin
      idle();
      waited++;
    end
    repeat (3) idle();
    checkOutput({tag, "_count"}, outQ.size(), n);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    canon = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};

    // Reset state
    repeat (2) @(negedge clk_in);
    checkOutput("rst_pos", pos_out, 0);
    checkOutput("rst_valid", data_valid_out, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_cfgerr", cfg_error_out, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    #1 checkOutput("rst_ready", data_ready_out, 1);

    // Canonical AAAAA -> BDZGO with 2-cycle latency
    clearQ();
    repeat (5) sendLetter(5'd0);
    drain(5, "canon");
    for (int i = 0; i < 5; i++) begin
      if (i < outQ.size()) begin
        checkOutput($sformatf("canon_%0d", i), outQ[i], canon[i]);
        checkOutput($sformatf("latency_%0d", i), outCyc[i] - accCyc[i], 2);
      end
    end
    checkOutput("canon_pos", pos_out, {5'd0, 5'd0, 5'd5});

    // Double step from ADU
    loadCfg(SEL_I_II_III, {5'd0, 5'd3, 5'd20});
    idle();
    checkOutput("ds_cfgerr", cfg_error_out, 0);
    checkOutput("ds_load_pos", pos_out, {5'd0, 5'd3, 5'd20});
    sendLetter(5'd0);
    idle();
    checkOutput("ds_pos_ADV", pos_out, {5'd0, 5'd3, 5'd21});
    sendLetter(5'd0);
    idle();
    checkOutput("ds_pos_AEW", pos_out, {5'd0, 5'd4, 5'd22});
    sendLetter(5'd0);
    idle();
    checkOutput("ds_pos_BFX", pos_out, {5'd1, 5'd5, 5'd23});
    repeat (4) idle();

    // Rejected loads leave the AAA {I,II,III} configuration intact
    loadCfg(SEL_I_II_III, POS_AAA);
    loadCfg({3'd0, 3'd0, 3'd2}, {5'd7, 5'd7, 5'd7});
    idle();
    checkOutput("rej_dup_cfgerr", cfg_error_out, 1);
    checkOutput("rej_dup_pos", pos_out, 0);
    loadCfg({3'd5, 3'd1, 3'd2}, POS_AAA);
    idle();
    checkOutput("rej_sel5_cfgerr", cfg_error_out, 1);
    loadCfg({3'd3, 3'd1, 3'd2}, {5'd0, 5'd0, 5'd26});
    idle();
    checkOutput("rej_pos26_cfgerr", cfg_error_out, 1);
    checkOutput("rej_hold_cfgerr", cfg_error_out, 1);
    clearQ();
    repeat (5) sendLetter(5'd0);
    drain(5, "rej_stream");
    for (int i = 0; i < 5; i++) begin
      if (i < outQ.size()) checkOutput($sformatf("rej_stream_%0d", i), outQ[i], canon[i]);
    end
    loadCfg(SEL_I_II_III, POS_AAA);
    idle();
    checkOutput("ok_cfgerr", cfg_error_out, 0);

    // Invalid letter between two A's is dropped without stepping
    clearQ();
    sendLetter(5'd0);
    sendLetter(5'd30);
    sendLetter(5'd0);
    drain(2, "inval");
    if (outQ.size() >= 2) begin
      checkOutput("inval_0", outQ[0], 1);
      checkOutput("inval_1", outQ[1], 3);
    end
    checkOutput("inval_pos", pos_out, {5'd0, 5'd0, 5'd2});

    // Involution with {V,II,IV} at XQZ
    loadCfg({3'd4, 3'd1, 3'd3}, {5'd23, 5'd16, 5'd25});
    clearQ();
    for (int i = 0; i < 26; i++) sendLetter(5'(i));
    drain(26, "inv_enc");
    for (int i = 0; i < 26; i++) begin
      cipher[i] = (i < outQ.size()) ? outQ[i] : 5'd31;
      checkOutput($sformatf("inv_noself_%0d", i), (cipher[i] != 5'(i)), 1);
    end
    loadCfg({3'd4, 3'd1, 3'd3}, {5'd23, 5'd16, 5'd25});
    clearQ();
    for (int i = 0; i < 26; i++) sendLetter(cipher[i]);
    drain(26, "inv_dec");
    for (int i = 0; i < 26; i++) begin
      if (i < outQ.size()) checkOutput($sformatf("inv_dec_%0d", i), outQ[i], i);
    end

    // Load mid-stream: in-flight letters keep old settings, load wins over a same-cycle letter
    loadCfg(SEL_I_II_III, POS_AAA);
    clearQ();
    sendLetter(5'd0);
    sendLetter(5'd0);
    applyStimulus(1'b1, 5'd0, 1'b1, SEL_I_II_III, POS_AAA);
    #1 checkOutput("mid_ready_load", data_ready_out, 0);
    sendLetter(5'd0);
    drain(3, "mid");
    if (outQ.size() >= 3) begin
      checkOutput("mid_0", outQ[0], 1);
      checkOutput("mid_1", outQ[1], 3);
      checkOutput("mid_2", outQ[2], 1);
    end
    checkOutput("mid_pos", pos_out, {5'd0, 5'd0, 5'd1});

    // Reset with letters in flight
    clearQ();
    sendLetter(5'd0);
    sendLetter(5'd0);
    @(posedge clk_in);
    #1;
    data_valid_in = 1'b0;
    rst_in = 1'b0;
    repeat (4) @(negedge clk_in);
    checkOutput("rstmid_count", outQ.size(), 0);
    checkOutput("rstmid_valid", data_valid_out, 0);
    checkOutput("rstmid_pos", pos_out, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    clearQ();
    sendLetter(5'd0);
    drain(1, "rstmid_after");
    if (outQ.size() >= 1) checkOutput("rstmid_after_0", outQ[0], 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
